mesi_snoop_responder: RTL and testbench

MESI_SNOOP_RESPONDER -- requirements
Module: mesi_snoop_responder

---
 rtl/mesi_pkg.sv | 26 ++
 rtl/mesi_snoop_responder_if.sv | 46 ++++
 rtl/mesi_snoop_decode.sv | 43 ++++
 rtl/mesi_snoop_responder.sv | 137 +++++++++++++
 tb/tb_mesi_snoop_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mesi_pkg.sv
// Shared MESI encodings for the cache and its snoop responder.
// Line states, bus snoop commands and snooper FSM states.
package mesi_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_E = 2'd2,
    ST_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_RD   = 2'd1,
    CMD_RDX  = 2'd2,
    CMD_UPGR = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    DECIDE  = 2'd2,
    RESPOND = 2'd3
  } snp_fsm_e;

endpackage

// File: rtl/mesi_snoop_responder_if.sv
// Snoop bus, response bus and state-array port of the snoop responder.
// slave = responder side, master = bus/cache side.
interface mesi_snoop_if #(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  logic               snp_valid;
  logic               snp_ready;
  logic [1:0]         snp_cmd;
  logic [ADDR_W-1:0]  snp_addr;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_shared;
  logic               rsp_dirty;
  logic [DATA_W-1:0]  rsp_data;
  logic               arr_rd_en;
  logic [INDEX_W-1:0] arr_idx;
  logic [1:0]         arr_rd_state;
  logic [TAG_W-1:0]   arr_rd_tag;
  logic [DATA_W-1:0]  arr_rd_data;
  logic               arr_wr_en;
  logic [1:0]         arr_wr_state;
  logic               core_lock;
  logic               proto_err;
  logic [15:0]        hit_cnt;

  modport slave (
    input  snp_valid, snp_cmd, snp_addr, rsp_ready,
    input  arr_rd_state, arr_rd_tag, arr_rd_data, core_lock,
    output snp_ready, rsp_valid, rsp_shared, rsp_dirty, rsp_data,
    output arr_rd_en, arr_idx, arr_wr_en, arr_wr_state,
    output proto_err, hit_cnt
  );

  modport master (
    output snp_valid, snp_cmd, snp_addr, rsp_ready,
    output arr_rd_state, arr_rd_tag, arr_rd_data, core_lock,
    input  snp_ready, rsp_valid, rsp_shared, rsp_dirty, rsp_data,
    input  arr_rd_en, arr_idx, arr_wr_en, arr_wr_state,
    input  proto_err, hit_cnt
  );
endinterface

// File: rtl/mesi_snoop_decode.sv
// MESI snoop transition decode: next line state and response bits
// for one snooped command against the current line state.
module mesi_snoop_decode
  import mesi_pkg::*;
(
  input  cmd_e  cmd_i,
  input  mesi_e state_i,
  input  logic  hit_i,
  output mesi_e next_state_o,
  output logic  shared_o,
  output logic  dirty_o,
  output logic  err_o
);

  always_comb begin
    next_state_o = state_i;
    shared_o     = 1'b0;
    dirty_o      = 1'b0;
    err_o        = 1'b0;
    unique case (1'b1)
      (!hit_i || cmd_i == CMD_NONE): ;
      (hit_i && cmd_i == CMD_RD): begin
        next_state_o = ST_S;
        shared_o     = 1'b1;
        dirty_o      = (state_i == ST_M);
      end
      (hit_i && cmd_i == CMD_RDX): begin
        next_state_o = ST_I;
        shared_o     = 1'b1;
        dirty_o      = (state_i == ST_M);
      end
      (hit_i && cmd_i == CMD_UPGR): begin
        shared_o = 1'b1;
        // Upgrade aimed at an exclusive owner means another
        // cache believes it shares a line we hold alone.
        if (state_i == ST_S) next_state_o = ST_I;
        else                 err_o        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mesi_snoop_responder.sv
// Bus snoop responder: looks up the local state array, answers the
// snoop and downgrades the line.
module mesi_snoop_responder
  import mesi_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input logic clk_i,
  input logic rst_ni,
  mesi_snoop_if.slave bus
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  snp_fsm_e state_q, state_d;

  cmd_e               cmd_q;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic               rsp_shared_q;
  logic               rsp_dirty_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               proto_err_q;
  logic [15:0]        hit_cnt_q, hit_cnt_d;

  logic       snp_ready, rsp_valid;
  logic       arr_rd_en, arr_wr_en;
  mesi_e      arr_wr_state;
  logic       accept, rsp_hs, hit;
  mesi_e      cur_st, nxt_st;
  logic       dec_shared, dec_dirty, dec_err;
  logic [1:0] unused_addr;

  assign unused_addr = bus.snp_addr[1:0];
  assign cur_st = mesi_e'(bus.arr_rd_state);
  assign hit    = (cur_st != ST_I) && (bus.arr_rd_tag == tag_q);
  assign accept = bus.snp_valid && snp_ready;
  assign rsp_hs = rsp_valid && bus.rsp_ready;

  mesi_snoop_decode u_decode (
    .cmd_i        (cmd_q),
    .state_i      (cur_st),
    .hit_i        (hit),
    .next_state_o (nxt_st),
    .shared_o     (dec_shared),
    .dirty_o      (dec_dirty),
    .err_o        (dec_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.snp_valid) state_d = LOOKUP;
      LOOKUP:  if (!bus.core_lock) state_d = DECIDE;
      DECIDE:  state_d = RESPOND;
      RESPOND: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snp_ready    = 1'b0;
    rsp_valid    = 1'b0;
    arr_rd_en    = 1'b0;
    arr_wr_en    = 1'b0;
    arr_wr_state = ST_I;
    unique case (state_q)
      IDLE:    snp_ready = 1'b1;
      LOOKUP:  arr_rd_en = !bus.core_lock;
      DECIDE: begin
        if (hit && nxt_st != cur_st) begin
          arr_wr_en    = 1'b1;
          arr_wr_state = nxt_st;
        end
      end
      RESPOND: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (rsp_hs && rsp_shared_q && hit_cnt_q != 16'hFFFF)
      hit_cnt_d = hit_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_q        <= CMD_NONE;
      idx_q        <= '0;
      tag_q        <= '0;
      rsp_shared_q <= 1'b0;
      rsp_dirty_q  <= 1'b0;
      rsp_data_q   <= '0;
      proto_err_q  <= 1'b0;
      hit_cnt_q    <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      if (accept) begin
        cmd_q <= cmd_e'(bus.snp_cmd);
        idx_q <= bus.snp_addr[INDEX_W+1:2];
        tag_q <= bus.snp_addr[ADDR_W-1:INDEX_W+2];
      end
      if (state_q == DECIDE) begin
        rsp_shared_q <= dec_shared;
        rsp_dirty_q  <= dec_dirty;
        rsp_data_q   <= dec_dirty ? bus.arr_rd_data : '0;
        proto_err_q  <= proto_err_q | dec_err;
      end else if (rsp_hs) begin
        rsp_shared_q <= 1'b0;
        rsp_dirty_q  <= 1'b0;
        rsp_data_q   <= '0;
      end
    end
  end

  assign bus.snp_ready    = snp_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_shared   = rsp_shared_q;
  assign bus.rsp_dirty    = rsp_dirty_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.arr_rd_en    = arr_rd_en;
  assign bus.arr_idx      = idx_q;
  assign bus.arr_wr_en    = arr_wr_en;
  assign bus.arr_wr_state = arr_wr_state;
  assign bus.proto_err    = proto_err_q;
  assign bus.hit_cnt      = hit_cnt_q;

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Directed bench for mesi_snoop_responder with a behavioural
// state array; vector table plus lock/reset/saturation sequences.
module tb_mesi_snoop_responder;
  import mesi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mesi_snoop_if #(.NUM_LINES(16), .ADDR_W(32), .DATA_W(32)) sif ();

  mesi_snoop_responder #(.NUM_LINES(16), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (sif)
  );

  logic [1:0]  mem_st [16];
  logic [25:0] mem_tag[16];
  logic [31:0] mem_dat[16];
  int          wr_cnt = 0;
  logic [1:0]  wr_last = 2'd0;

  always @(posedge clk) begin
    if (sif.arr_rd_en) begin
      sif.arr_rd_state <= mem_st[sif.arr_idx];
      sif.arr_rd_tag   <= mem_tag[sif.arr_idx];
      sif.arr_rd_data  <= mem_dat[sif.arr_idx];
    end
    if (sif.arr_wr_en) begin
      mem_st[sif.arr_idx] <= sif.arr_wr_state;
      wr_cnt  <= wr_cnt + 1;
      wr_last <= sif.arr_wr_state;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] adr(input int idx, input int tag);
    return (32'(tag) << 6) | (32'(idx) << 2);
  endfunction

  task automatic set_line(input int i, input logic [1:0] st,
                          input logic [25:0] tg, input logic [31:0] d);
    mem_st[i] = st; mem_tag[i] = tg; mem_dat[i] = d;
  endtask

  // Runs one snoop; lat counts cycles from accept to rsp_valid.
  task automatic snoop(input logic [1:0] cmd, input logic [31:0] a,
                       input int lock_n, input int hold_n,
                       output int lat, output logic sh, output logic dt,
                       output logic [31:0] dat, output logic stable,
                       output logic rd_bad);
    int n;
    lat = -1; sh = 0; dt = 0; dat = 0; stable = 1; rd_bad = 0;
    @(negedge clk);
    sif.snp_valid = 1'b1; sif.snp_cmd = cmd; sif.snp_addr = a;
    @(posedge clk);
    #1 sif.snp_valid = 1'b0; sif.snp_cmd = 2'd0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      sif.core_lock = (n <= lock_n);
      #1;
      if (sif.core_lock && sif.arr_rd_en) rd_bad = 1;
      if (sif.rsp_valid) break;
    end
    sif.core_lock = 1'b0;
    if (sif.rsp_valid) begin
      lat = n; sh = sif.rsp_shared; dt = sif.rsp_dirty; dat = sif.rsp_data;
      for (int h = 0; h < hold_n; h++) begin
        @(negedge clk);
        if (!sif.rsp_valid || sif.rsp_shared !== sh ||
            sif.rsp_dirty !== dt || sif.rsp_data !== dat) stable = 0;
      end
      @(negedge clk);
      sif.rsp_ready = 1'b1;
      @(posedge clk);
      #1 sif.rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] a;
    logic        sh;
    logic        dt;
    logic [31:0] dat;
    int          wr;
    logic [1:0]  wst;
    logic        err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int lat, w0;
    logic sh, dt, stb, rdb;
    logic [31:0] dat;
    logic [15:0] exp_hits;

    sif.snp_valid = 0; sif.snp_cmd = 0; sif.snp_addr = 0;
    sif.rsp_ready = 0; sif.core_lock = 0;
    sif.arr_rd_state = 0; sif.arr_rd_tag = 0; sif.arr_rd_data = 0;
    for (int i = 0; i < 16; i++) set_line(i, ST_I, 26'd0, 32'd0);
    set_line(1,  ST_S, 26'h1,  32'h11);
    set_line(2,  ST_M, 26'h3,  32'h2222);
    set_line(3,  ST_M, 26'h10, 32'hDEADBEEF);
    set_line(4,  ST_E, 26'h4,  32'h44);
    set_line(5,  ST_E, 26'h22, 32'h55);
    set_line(6,  ST_E, 26'h6,  32'h66);
    set_line(7,  ST_S, 26'h7,  32'h77);
    set_line(9,  ST_S, 26'h9,  32'h99);
    set_line(11, ST_M, 26'hAB, 32'hCAFEF00D);
    set_line(13, ST_M, 26'h1,  32'h13131313);
    set_line(14, ST_E, 26'hE,  32'hEE);

    tbl[0]  = '{CMD_RD,   adr(3, 'h10), 1, 1, 32'hDEADBEEF, 1, ST_S, 0};
    tbl[1]  = '{CMD_RD,   adr(3, 'h10), 1, 0, 0, 0, ST_I, 0};
    tbl[2]  = '{CMD_RDX,  adr(5, 'h22), 1, 0, 0, 1, ST_I, 0};
    tbl[3]  = '{CMD_RDX,  adr(5, 'h22), 0, 0, 0, 0, ST_I, 0};
    tbl[4]  = '{CMD_RD,   adr(7, 'h8),  0, 0, 0, 0, ST_I, 0};
    tbl[5]  = '{CMD_NONE, adr(7, 'h7),  0, 0, 0, 0, ST_I, 0};
    tbl[6]  = '{CMD_UPGR, adr(7, 'h7),  1, 0, 0, 1, ST_I, 0};
    tbl[7]  = '{CMD_RD,   adr(4, 'h4),  1, 0, 0, 1, ST_S, 0};
    tbl[8]  = '{CMD_RDX,  adr(9, 'h9),  1, 0, 0, 1, ST_I, 0};
    tbl[9]  = '{CMD_RDX,  adr(11,'hAB), 1, 1, 32'hCAFEF00D, 1, ST_I, 0};
    tbl[10] = '{CMD_RD,   adr(0, 'h0),  0, 0, 0, 0, ST_I, 0};
    tbl[11] = '{CMD_UPGR, adr(2, 'h3),  1, 0, 0, 0, ST_I, 1};
    tbl[12] = '{CMD_RD,   adr(3, 'h10), 1, 0, 0, 0, ST_I, 1};
    tbl[13] = '{CMD_UPGR, adr(6, 'h6),  1, 0, 0, 0, ST_I, 1};
    tbl[14] = '{CMD_RDX,  adr(2, 'h3),  1, 1, 32'h2222, 1, ST_I, 1};
    tbl[15] = '{CMD_UPGR, adr(5, 'h22), 0, 0, 0, 0, ST_I, 1};

    #1;
    chk("rst_snp_ready", 32'(sif.snp_ready), 1);
    chk("rst_rsp_valid", 32'(sif.rsp_valid), 0);
    chk("rst_rsp_data", sif.rsp_data, 0);
    chk("rst_arr_idx", 32'(sif.arr_idx), 0);
    chk("rst_wr_en", 32'(sif.arr_wr_en), 0);
    chk("rst_hit_cnt", 32'(sif.hit_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    exp_hits = 0;
    foreach (tbl[i]) begin
      w0 = wr_cnt;
      snoop(tbl[i].cmd, tbl[i].a, 0, 0, lat, sh, dt, dat, stb, rdb);
      if (tbl[i].sh) exp_hits++;
      chk($sformatf("v%0d_lat", i), 32'(lat), 3);
      chk($sformatf("v%0d_shared", i), 32'(sh), 32'(tbl[i].sh));
      chk($sformatf("v%0d_dirty", i), 32'(dt), 32'(tbl[i].dt));
      chk($sformatf("v%0d_data", i), dat, tbl[i].dat);
      chk($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - w0), 32'(tbl[i].wr));
      if (tbl[i].wr != 0)
        chk($sformatf("v%0d_wr_state", i), 32'(wr_last), 32'(tbl[i].wst));
      chk($sformatf("v%0d_proto_err", i), 32'(sif.proto_err),
          32'(tbl[i].err));
      chk($sformatf("v%0d_hit_cnt", i), 32'(sif.hit_cnt), 32'(exp_hits));
    end

    // Four locked LOOKUP cycles, then a response held for five cycles.
    w0 = wr_cnt;
    snoop(CMD_RD, adr(13, 'h1), 4, 5, lat, sh, dt, dat, stb, rdb);
    chk("lock_lat", 32'(lat), 7);
    chk("lock_rd_en", 32'(rdb), 0);
    chk("lock_stable", 32'(stb), 1);
    chk("lock_dirty", 32'(dt), 1);
    chk("lock_data", dat, 32'h13131313);
    chk("lock_wr_state", 32'(wr_last), ST_S);
    chk("lock_wr_cnt", 32'(wr_cnt - w0), 1);

    // Reset while the snooper sits in DECIDE on a downgrading hit.
    w0 = wr_cnt;
    @(negedge clk);
    sif.snp_valid = 1'b1; sif.snp_cmd = CMD_RDX; sif.snp_addr = adr(14, 'hE);
    @(posedge clk);
    #1 sif.snp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("decide_wr_en", 32'(sif.arr_wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(sif.arr_wr_en), 0);
    chk("mid_rst_rsp_valid", 32'(sif.rsp_valid), 0);
    chk("mid_rst_snp_ready", 32'(sif.snp_ready), 1);
    chk("mid_rst_proto_err", 32'(sif.proto_err), 0);
    chk("mid_rst_hit_cnt", 32'(sif.hit_cnt), 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_no_write", 32'(wr_cnt - w0), 0);
    chk("mid_rst_line_kept", 32'(mem_st[14]), ST_E);
    rst_n = 1'b1;

    // Stand in for 65534 earlier hits, then saturate.
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.hit_cnt_q;
    snoop(CMD_RD, adr(1, 'h1), 0, 0, lat, sh, dt, dat, stb, rdb);
    chk("sat_hit1_shared", 32'(sh), 1);
    chk("sat_hit1_cnt", 32'(sif.hit_cnt), 32'hFFFF);
    snoop(CMD_RD, adr(1, 'h1), 0, 0, lat, sh, dt, dat, stb, rdb);
    chk("sat_hit2_shared", 32'(sh), 1);
    chk("sat_hit2_cnt", 32'(sif.hit_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
